// File: rtl/id_stage.sv
// id_stage -- instruction decode stage of a 5-stage MIPS-subset pipeline.
//
// Decodes the IF/ID instruction and reads the register file. It also resolves
// load-use stalls, j/jal/jr/jalr redirects and flushes for branches taken in
// MEM. The result is loaded into the ID/EX pipeline register.
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   if_id_pc_plus_4/inst    IF/ID register contents (inst 0 = nop)
//   activeBranch            taken branch resolved in MEM; flushes this stage
//   wb_reg_write/wr_reg/... register-file write port driven by WB
//   PCSrc1, PCSrc2          PC select (00 seq, 01 j target, 10 jr target) / PC hold
//   Jump_addr               redirect target for IF
//   regOption               IF/ID control: 00 load, 01 flush, 10 hold
//   id_ex_*                 registered ID/EX fields (ctrl layout below)
//     ctrl [11]reg_write [10]mem_read [9]mem_write [8:7]mem_to_reg
//          [6]alu_src [5:2]alu_op [1:0]branch
//
// Build option: define ID_WB_BYPASS_EN to forward the WB write data to
// same-cycle register reads, including the jr/jalr target.
module id_stage #(
  parameter int unsigned RA_IDX = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_id_pc_plus_4,
  input  logic [31:0] if_id_inst,
  input  logic        activeBranch,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_wr_reg,
  input  logic [31:0] wb_wr_data,
  output logic [1:0]  PCSrc1,
  output logic        PCSrc2,
  output logic [31:0] Jump_addr,
  output logic [1:0]  regOption,
  output logic [31:0] id_ex_pc_plus_4,
  output logic [31:0] id_ex_rs_data,
  output logic [31:0] id_ex_rt_data,
  output logic [31:0] id_ex_imm,
  output logic [4:0]  id_ex_rs,
  output logic [4:0]  id_ex_rt,
  output logic [4:0]  id_ex_wr_reg,
  output logic [11:0] id_ex_ctrl
);

  localparam logic [4:0] RA = RA_IDX[4:0];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;

  assign op    = if_id_inst[31:26];
  assign rs    = if_id_inst[25:21];
  assign rt    = if_id_inst[20:16];
  assign rd    = if_id_inst[15:11];
  assign shamt = if_id_inst[10:6];
  assign funct = if_id_inst[5:0];
  assign imm16 = if_id_inst[15:0];

  logic [31:0] rf_q [32];
  logic [31:0] rs_val, rt_val;

  logic        valid, rw, mr, mw, asrc, uses_rs, uses_rt, is_j, is_jr;
  logic [1:0]  m2r, br;
  logic [3:0]  aop;
  logic [4:0]  wr;
  logic [31:0] imm;
  logic [11:0] ctrl;
  logic        load_use, bubble;

  logic [31:0] pc4_q, rs_data_q, rt_data_q, imm_q;
  logic [4:0]  rs_q, rt_q, wr_q;
  logic [11:0] ctrl_q;

  // Register-file read ports; register 0 is hard-wired to zero.
  always_comb begin
    if (rs == 5'd0) rs_val = 32'd0;
`ifdef ID_WB_BYPASS_EN
    else if (wb_reg_write && (wb_wr_reg == rs)) rs_val = wb_wr_data;
`endif
    else rs_val = rf_q[rs];
    if (rt == 5'd0) rt_val = 32'd0;
`ifdef ID_WB_BYPASS_EN
    else if (wb_reg_write && (wb_wr_reg == rt)) rt_val = wb_wr_data;
`endif
    else rt_val = rf_q[rt];
  end

  // Instruction decode into ID/EX control, destination and immediate.
  always_comb begin
    valid = 1'b0; rw = 1'b0; mr = 1'b0; mw = 1'b0; m2r = 2'b00; asrc = 1'b0;
    aop = 4'd0; br = 2'b00; wr = 5'd0; imm = 32'd0;
    uses_rs = 1'b0; uses_rt = 1'b0; is_j = 1'b0; is_jr = 1'b0;
    // Common I-type shape; individual opcodes below adjust it.
    if (op inside {6'd4, 6'd5, [6'd8:6'd15], 6'd35, 6'd43}) begin
      valid = 1'b1; rw = 1'b1; asrc = 1'b1; wr = rt; uses_rs = 1'b1;
      imm = {{16{imm16[15]}}, imm16};
    end else begin
      valid = 1'b0;
    end
    case (op)
      6'd0: begin
        valid = 1'b1; rw = 1'b1; wr = rd; uses_rs = 1'b1; uses_rt = 1'b1;
        case (funct)
          6'd32, 6'd33: aop = 4'd0;
          6'd34, 6'd35: aop = 4'd1;
          6'd36:        aop = 4'd2;
          6'd37:        aop = 4'd3;
          6'd38:        aop = 4'd4;
          6'd39:        aop = 4'd5;
          6'd42:        aop = 4'd6;
          6'd43:        aop = 4'd7;
          // Shifts operate on rt; the shift amount rides in imm.
          6'd0: begin aop = 4'd8;  uses_rs = 1'b0; imm = {27'd0, shamt}; end
          6'd2: begin aop = 4'd9;  uses_rs = 1'b0; imm = {27'd0, shamt}; end
          6'd3: begin aop = 4'd10; uses_rs = 1'b0; imm = {27'd0, shamt}; end
          6'd8: begin rw = 1'b0; uses_rt = 1'b0; is_jr = 1'b1; end
          6'd9: begin
            m2r = 2'b10; uses_rt = 1'b0; is_jr = 1'b1;
            wr = (rd == 5'd0) ? RA : rd;
          end
          default: valid = 1'b0;
        endcase
      end
      6'd2:         begin valid = 1'b1; is_j = 1'b1; end
      6'd3:         begin valid = 1'b1; is_j = 1'b1; rw = 1'b1; m2r = 2'b10; wr = RA; end
      6'd4:         begin rw = 1'b0; asrc = 1'b0; aop = 4'd1; br = 2'b01; uses_rt = 1'b1; end
      6'd5:         begin rw = 1'b0; asrc = 1'b0; aop = 4'd1; br = 2'b10; uses_rt = 1'b1; end
      6'd8, 6'd9:   aop = 4'd0;
      6'd10:        aop = 4'd6;
      6'd11:        aop = 4'd7;
      6'd12:        begin aop = 4'd2; imm = {16'd0, imm16}; end
      6'd13:        begin aop = 4'd3; imm = {16'd0, imm16}; end
      6'd14:        begin aop = 4'd4; imm = {16'd0, imm16}; end
      6'd15:        begin aop = 4'd11; imm = {imm16, 16'd0}; uses_rs = 1'b0; end
      6'd35:        begin mr = 1'b1; m2r = 2'b01; end
      6'd43:        begin rw = 1'b0; mw = 1'b1; uses_rt = 1'b1; end
      default:      valid = 1'b0;
    endcase
    // Unknown encodings and the all-zero nop carry no effect at all.
    if (!valid || (if_id_inst == 32'd0)) begin
      valid = 1'b0; rw = 1'b0; mr = 1'b0; mw = 1'b0; m2r = 2'b00; asrc = 1'b0;
      aop = 4'd0; br = 2'b00; wr = 5'd0; imm = 32'd0;
      uses_rs = 1'b0; uses_rt = 1'b0; is_j = 1'b0; is_jr = 1'b0;
    end else begin
      rw = rw && (wr != 5'd0);  // writes to $0 are dropped at decode
    end
  end

  assign ctrl = {rw, mr, mw, m2r, asrc, aop, br};

  // A load in EX whose destination this instruction reads must stall one cycle.
  assign load_use = ctrl_q[10] && (wr_q != 5'd0) &&
                    ((uses_rs && (wr_q == rs)) || (uses_rt && (wr_q == rt)));

  // PC / IF-ID steering in priority: branch flush, load-use stall, jump, normal.
  always_comb begin
    PCSrc1 = 2'b00; PCSrc2 = 1'b0; Jump_addr = 32'd0; regOption = 2'b00; bubble = 1'b0;
    if (activeBranch) begin
      regOption = 2'b01; bubble = 1'b1;
    end else if (load_use) begin
      PCSrc2 = 1'b1; regOption = 2'b10; bubble = 1'b1;
    end else if (is_j) begin
      PCSrc1 = 2'b01; regOption = 2'b01;
      Jump_addr = {if_id_pc_plus_4[31:28], if_id_inst[25:0], 2'b00};
    end else if (is_jr) begin
      PCSrc1 = 2'b10; regOption = 2'b01; Jump_addr = rs_val;
    end else begin
      regOption = 2'b00;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk) begin
    if (reset || bubble || !valid) begin
      pc4_q <= 32'd0; rs_data_q <= 32'd0; rt_data_q <= 32'd0; imm_q <= 32'd0;
      rs_q <= 5'd0; rt_q <= 5'd0; wr_q <= 5'd0; ctrl_q <= 12'd0;
    end else begin
      pc4_q <= if_id_pc_plus_4; rs_data_q <= rs_val; rt_data_q <= rt_val; imm_q <= imm;
      rs_q <= rs; rt_q <= rt; wr_q <= wr; ctrl_q <= ctrl;
    end
  end

  // Register-file write port from WB.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else if (wb_reg_write && (wb_wr_reg != 5'd0)) begin
      rf_q[wb_wr_reg] <= wb_wr_data;
    end
  end

  assign id_ex_pc_plus_4 = pc4_q;
  assign id_ex_rs_data   = rs_data_q;
  assign id_ex_rt_data   = rt_data_q;
  assign id_ex_imm       = imm_q;
  assign id_ex_rs        = rs_q;
  assign id_ex_rt        = rt_q;
  assign id_ex_wr_reg    = wr_q;
  assign id_ex_ctrl      = ctrl_q;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage -- directed bench for id_stage with a mnemonic-level reference model.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] if_id_pc_plus_4 = 32'd0, if_id_inst = 32'd0;
  logic        activeBranch = 1'b0, wb_reg_write = 1'b0;
  logic [4:0]  wb_wr_reg = 5'd0;
  logic [31:0] wb_wr_data = 32'd0;
  logic [1:0]  PCSrc1, regOption;
  logic        PCSrc2;
  logic [31:0] Jump_addr, id_ex_pc_plus_4, id_ex_rs_data, id_ex_rt_data, id_ex_imm;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_wr_reg;
  logic [11:0] id_ex_ctrl;

  always #5 clk = ~clk;

  id_stage #(.RA_IDX(31)) dut (
    .clk(clk), .reset(reset), .if_id_pc_plus_4(if_id_pc_plus_4), .if_id_inst(if_id_inst),
    .activeBranch(activeBranch), .wb_reg_write(wb_reg_write), .wb_wr_reg(wb_wr_reg),
    .wb_wr_data(wb_wr_data), .PCSrc1(PCSrc1), .PCSrc2(PCSrc2), .Jump_addr(Jump_addr),
    .regOption(regOption), .id_ex_pc_plus_4(id_ex_pc_plus_4), .id_ex_rs_data(id_ex_rs_data),
    .id_ex_rt_data(id_ex_rt_data), .id_ex_imm(id_ex_imm), .id_ex_rs(id_ex_rs),
    .id_ex_rt(id_ex_rt), .id_ex_wr_reg(id_ex_wr_reg), .id_ex_ctrl(id_ex_ctrl)
  );

  typedef enum int {
    M_NOP, M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU, M_SLL, M_SRL, M_SRA,
    M_JR, M_JALR, M_ADDI, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LUI, M_LW, M_SW,
    M_BEQ, M_BNE, M_J, M_JAL
  } mn_t;

  typedef struct packed {
    logic [31:0] pc4, rsd, rtd, imm;
    logic [4:0]  rs, rt, wr;
    logic [11:0] ctrl;
  } idex_t;

  typedef struct packed {
    logic [1:0]  pcsrc1;
    logic        pcsrc2;
    logic [31:0] jaddr;
    logic [1:0]  regopt;
    logic        bubble;
  } comb_t;

  idex_t       m_idex;
  logic [31:0] mrf [32];
  comb_t       cmp_c;
  int          checks = 0, errors = 0;
  bit          cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic mn_t classify(input logic [31:0] ins);
    mn_t m;
    m = M_NOP;
    if (ins != 32'd0) begin
      case (ins[31:26])
        6'd0: case (ins[5:0])
          6'd32, 6'd33: m = M_ADD;   6'd34, 6'd35: m = M_SUB;
          6'd36: m = M_AND;  6'd37: m = M_OR;   6'd38: m = M_XOR;  6'd39: m = M_NOR;
          6'd42: m = M_SLT;  6'd43: m = M_SLTU; 6'd0:  m = M_SLL;  6'd2:  m = M_SRL;
          6'd3:  m = M_SRA;  6'd8:  m = M_JR;   6'd9:  m = M_JALR;
          default: m = M_NOP;
        endcase
        6'd2: m = M_J;     6'd3: m = M_JAL;    6'd4: m = M_BEQ;   6'd5: m = M_BNE;
        6'd8, 6'd9: m = M_ADDI;  6'd10: m = M_SLTI;  6'd11: m = M_SLTIU;
        6'd12: m = M_ANDI; 6'd13: m = M_ORI;   6'd14: m = M_XORI; 6'd15: m = M_LUI;
        6'd35: m = M_LW;   6'd43: m = M_SW;
        default: m = M_NOP;
      endcase
    end
    return m;
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
    if (wb_reg_write && (wb_wr_reg == r)) return wb_wr_data;
`endif
    return mrf[r];
  endfunction

  function automatic logic [3:0] alu_of(input mn_t m);
    case (m)
      M_SUB, M_BEQ, M_BNE: return 4'd1;
      M_AND, M_ANDI: return 4'd2;   M_OR, M_ORI: return 4'd3;
      M_XOR, M_XORI: return 4'd4;   M_NOR: return 4'd5;
      M_SLT, M_SLTI: return 4'd6;   M_SLTU, M_SLTIU: return 4'd7;
      M_SLL: return 4'd8;  M_SRL: return 4'd9;  M_SRA: return 4'd10;  M_LUI: return 4'd11;
      default: return 4'd0;
    endcase
  endfunction

  function automatic bit reads_rs(input mn_t m);
    return m inside {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU, M_JR, M_JALR,
                     M_ADDI, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LW, M_SW, M_BEQ, M_BNE};
  endfunction

  function automatic bit reads_rt(input mn_t m);
    return m inside {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
                     M_SLL, M_SRL, M_SRA, M_SW, M_BEQ, M_BNE};
  endfunction

  function automatic idex_t model_decode(input logic [31:0] ins, input logic [31:0] pc4);
    idex_t e;
    mn_t   m;
    bit    wflag;
    e = '0;
    m = classify(ins);
    if (m == M_NOP) return e;
    e.pc4 = pc4;
    e.rs  = ins[25:21];
    e.rt  = ins[20:16];
    e.rsd = rd_model(e.rs);
    e.rtd = rd_model(e.rt);
    case (m)
      M_ADDI, M_SLTI, M_SLTIU, M_LW, M_SW, M_BEQ, M_BNE: e.imm = {{16{ins[15]}}, ins[15:0]};
      M_ANDI, M_ORI, M_XORI: e.imm = {16'h0000, ins[15:0]};
      M_LUI: e.imm = {ins[15:0], 16'h0000};
      M_SLL, M_SRL, M_SRA: e.imm = {27'd0, ins[10:6]};
      default: e.imm = 32'd0;
    endcase
    case (m)
      M_JALR: e.wr = (ins[15:11] == 5'd0) ? 5'd31 : ins[15:11];
      M_JAL:  e.wr = 5'd31;
      M_J:    e.wr = 5'd0;
      M_ADDI, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LUI, M_LW, M_SW, M_BEQ, M_BNE:
              e.wr = ins[20:16];
      default: e.wr = ins[15:11];
    endcase
    wflag = !(m inside {M_SW, M_BEQ, M_BNE, M_J, M_JR});
    e.ctrl[11]  = wflag && (e.wr != 5'd0);
    e.ctrl[10]  = (m == M_LW);
    e.ctrl[9]   = (m == M_SW);
    e.ctrl[8:7] = (m == M_LW) ? 2'b01 : ((m == M_JAL || m == M_JALR) ? 2'b10 : 2'b00);
    e.ctrl[6]   = m inside {M_ADDI, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LUI, M_LW, M_SW};
    e.ctrl[5:2] = alu_of(m);
    e.ctrl[1:0] = (m == M_BEQ) ? 2'b01 : ((m == M_BNE) ? 2'b10 : 2'b00);
    return e;
  endfunction

  function automatic comb_t model_comb();
    comb_t    c;
    mn_t      m;
    logic [4:0] ld;
    bit       hz;
    c  = '0;
    m  = classify(if_id_inst);
    ld = m_idex.ctrl[10] ? m_idex.wr : 5'd0;
    hz = (ld != 5'd0) && ((reads_rs(m) && (if_id_inst[25:21] == ld)) ||
                          (reads_rt(m) && (if_id_inst[20:16] == ld)));
    if (activeBranch) begin
      c.regopt = 2'b01; c.bubble = 1'b1;
    end else if (hz) begin
      c.pcsrc2 = 1'b1; c.regopt = 2'b10; c.bubble = 1'b1;
    end else if (m == M_J || m == M_JAL) begin
      c.pcsrc1 = 2'b01; c.regopt = 2'b01;
      c.jaddr = {if_id_pc_plus_4[31:28], if_id_inst[25:0], 2'b00};
    end else if (m == M_JR || m == M_JALR) begin
      c.pcsrc1 = 2'b10; c.regopt = 2'b01; c.jaddr = rd_model(if_id_inst[25:21]);
    end
    return c;
  endfunction

  function automatic bit model_bubble();
    comb_t c;
    c = model_comb();
    return c.bubble;
  endfunction

  // Reference model state: ID/EX contents and register file.
  always @(posedge clk) begin
    if (reset) begin
      m_idex <= '0;
      for (int i = 0; i < 32; i++) mrf[i] <= 32'd0;
    end else begin
      m_idex <= model_bubble() ? '0 : model_decode(if_id_inst, if_id_pc_plus_4);
      if (wb_reg_write && (wb_wr_reg != 5'd0)) mrf[wb_wr_reg] <= wb_wr_data;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_c = model_comb();
      chk("PCSrc1", {30'd0, PCSrc1}, {30'd0, cmp_c.pcsrc1});
      chk("PCSrc2", {31'd0, PCSrc2}, {31'd0, cmp_c.pcsrc2});
      chk("Jump_addr", Jump_addr, cmp_c.jaddr);
      chk("regOption", {30'd0, regOption}, {30'd0, cmp_c.regopt});
      chk("id_ex_pc_plus_4", id_ex_pc_plus_4, m_idex.pc4);
      chk("id_ex_rs_data", id_ex_rs_data, m_idex.rsd);
      chk("id_ex_rt_data", id_ex_rt_data, m_idex.rtd);
      chk("id_ex_imm", id_ex_imm, m_idex.imm);
      chk("id_ex_rs", {27'd0, id_ex_rs}, {27'd0, m_idex.rs});
      chk("id_ex_rt", {27'd0, id_ex_rt}, {27'd0, m_idex.rt});
      chk("id_ex_wr_reg", {27'd0, id_ex_wr_reg}, {27'd0, m_idex.wr});
      chk("id_ex_ctrl", {20'd0, id_ex_ctrl}, {20'd0, m_idex.ctrl});
    end
  end

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc4, input logic ab,
                       input logic wbw, input logic [4:0] wbr, input logic [31:0] wbd,
                       input logic rst);
    @(posedge clk);
    #1;
    if_id_inst = ins; if_id_pc_plus_4 = pc4; activeBranch = ab;
    wb_reg_write = wbw; wb_wr_reg = wbr; wb_wr_data = wbd; reset = rst;
  endtask

  task automatic op(input logic [31:0] ins);
    drive(ins, 32'h0040_0010, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  localparam logic [31:0] ADD3   = 32'h0022_1820;  // add $3,$1,$2
  localparam logic [31:0] LW4    = 32'h8C24_0000;  // lw $4,0($1)
  localparam logic [31:0] ADD5   = 32'h0082_2820;  // add $5,$4,$2
  localparam logic [31:0] JAL    = 32'h0C00_0100;  // jal 0x0000100
  localparam logic [31:0] LW7    = 32'h8C27_0000;  // lw $7,0($1)
  localparam logic [31:0] JR7    = 32'h00E0_0008;  // jr $7
  localparam logic [31:0] JR6    = 32'h00C0_0008;  // jr $6
  localparam logic [31:0] ADD9   = 32'h0000_4820;  // add $9,$0,$0
  localparam logic [31:0] ADDI10 = 32'h202A_FFFF;  // addi $10,$1,-1
  localparam logic [31:0] ORI11  = 32'h344B_8000;  // ori $11,$2,0x8000
  localparam logic [31:0] LUI12  = 32'h3C0C_ABCD;  // lui $12,0xABCD
  localparam logic [31:0] SRA13  = 32'h0002_68C3;  // sra $13,$2,3

  initial begin
    @(posedge clk);
    @(posedge clk);
    #1 cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_ctrl", {20'd0, id_ex_ctrl}, 32'd0);
    chk("reset_regOption", {30'd0, regOption}, 32'd0);
    chk("reset_PCSrc2", {31'd0, PCSrc2}, 32'd0);

    // Preload $1=5, $2=7, $7=0x1234, $6=0x11111111.
    drive(32'd0, 32'd0, 1'b0, 1'b1, 5'd1, 32'd5, 1'b0);
    drive(32'd0, 32'd0, 1'b0, 1'b1, 5'd2, 32'd7, 1'b0);
    drive(32'd0, 32'd0, 1'b0, 1'b1, 5'd7, 32'h0000_1234, 1'b0);
    drive(32'd0, 32'd0, 1'b0, 1'b1, 5'd6, 32'h1111_1111, 1'b0);

    op(ADD3); op(32'd0); @(negedge clk);
    chk("add_rs_data", id_ex_rs_data, 32'd5);
    chk("add_rt_data", id_ex_rt_data, 32'd7);
    chk("add_wr_reg", {27'd0, id_ex_wr_reg}, 32'd3);
    chk("add_ctrl", {20'd0, id_ex_ctrl}, 32'h0000_0800);

    op(LW4); op(ADD5); @(negedge clk);
    chk("lu_PCSrc2", {31'd0, PCSrc2}, 32'd1);
    chk("lu_regOption", {30'd0, regOption}, 32'd2);
    op(ADD5); @(negedge clk);
    chk("lu_bubble_ctrl", {20'd0, id_ex_ctrl}, 32'd0);
    chk("lu_released", {31'd0, PCSrc2}, 32'd0);
    op(32'd0); @(negedge clk);
    chk("lu_add_wr", {27'd0, id_ex_wr_reg}, 32'd5);

    drive(JAL, 32'h0040_0008, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0); @(negedge clk);
    chk("jal_PCSrc1", {30'd0, PCSrc1}, 32'd1);
    chk("jal_Jump_addr", Jump_addr, 32'h0000_0400);
    chk("jal_regOption", {30'd0, regOption}, 32'd1);
    op(32'd0); @(negedge clk);
    chk("jal_wr_reg", {27'd0, id_ex_wr_reg}, 32'd31);
    chk("jal_mem_to_reg", {30'd0, id_ex_ctrl[8:7]}, 32'd2);

    op(LW4); drive(ADD5, 32'h0040_0010, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0); @(negedge clk);
    chk("ab_regOption", {30'd0, regOption}, 32'd1);
    chk("ab_PCSrc2", {31'd0, PCSrc2}, 32'd0);
    op(32'd0); @(negedge clk);
    chk("ab_bubble_ctrl", {20'd0, id_ex_ctrl}, 32'd0);

    op(LW7); op(JR7); @(negedge clk);
    chk("jr_stall_PCSrc1", {30'd0, PCSrc1}, 32'd0);
    chk("jr_stall_PCSrc2", {31'd0, PCSrc2}, 32'd1);
    op(JR7); @(negedge clk);
    chk("jr_PCSrc1", {30'd0, PCSrc1}, 32'd2);
    chk("jr_Jump_addr", Jump_addr, 32'h0000_1234);
    op(32'd0);

    drive(JR6, 32'h0040_0010, 1'b0, 1'b1, 5'd6, 32'hDEAD_BEEF, 1'b0); @(negedge clk);
`ifdef ID_WB_BYPASS_EN
    chk("byp_jr_target", Jump_addr, 32'hDEAD_BEEF);
`else
    chk("byp_jr_target", Jump_addr, 32'h1111_1111);
`endif
    op(32'd0); @(negedge clk);
`ifdef ID_WB_BYPASS_EN
    chk("byp_rs_data", id_ex_rs_data, 32'hDEAD_BEEF);
`else
    chk("byp_rs_data", id_ex_rs_data, 32'h1111_1111);
`endif
    drive(32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 32'd5, 1'b0);
    op(ADD9); op(32'd0); @(negedge clk);
    chk("r0_rs_data", id_ex_rs_data, 32'd0);

    op(ADDI10); op(ORI11); @(negedge clk);
    chk("addi_imm", id_ex_imm, 32'hFFFF_FFFF);
    op(LUI12); @(negedge clk);
    chk("ori_imm", id_ex_imm, 32'h0000_8000);
    op(SRA13); @(negedge clk);
    chk("lui_imm", id_ex_imm, 32'hABCD_0000);
    op(32'hAC22_0004); @(negedge clk);          // sw $2,4($1)
    chk("sra_imm", id_ex_imm, 32'd3);
    op(32'h1022_FFFE); op(32'h1422_FFFE);       // beq / bne
    op(32'h00A0_0009);                           // jalr $5
    drive(32'h0BFF_FFFF, 32'hF000_0000, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0); @(negedge clk);
    chk("j_Jump_addr", Jump_addr, 32'hFFFF_FFFC);
    op(32'hFC00_0000);                           // undefined opcode
    op(32'h8C20_0000); op(32'h0002_2820); @(negedge clk);  // lw $0 then add $5,$0,$2
    chk("lw_r0_no_stall", {31'd0, PCSrc2}, 32'd0);
    op(LW4); op(32'hAC24_0000); @(negedge clk); // sw $4 after lw $4 (rt use)
    chk("sw_rt_stall", {31'd0, PCSrc2}, 32'd1);
    op(32'd0);

    // Reset taken while a stall is being signalled.
    op(LW4); drive(ADD5, 32'h0040_0010, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1); @(negedge clk);
    chk("rst_stall_before", {31'd0, PCSrc2}, 32'd1);
    op(ADD3); @(negedge clk);
    chk("rst_stall_cleared", {31'd0, PCSrc2}, 32'd0);
    chk("rst_idex_ctrl", {20'd0, id_ex_ctrl}, 32'd0);
    op(32'd0); @(negedge clk);
    chk("rst_regs_cleared", id_ex_rs_data, 32'd0);
    op(32'd0); op(32'd0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter RA_IDX, default 31, link register index written by jal/jalr.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 if_id_pc_plus_4  input  32  PC+4 from the IF/ID register.
REQ-005 if_id_inst  input  32  instruction from the IF/ID register; 0 = nop.
REQ-006 activeBranch  input  1  taken branch resolved in MEM; flushes this stage.
REQ-007 wb_reg_write, wb_wr_reg, wb_wr_data  input  1/5/32  register-file write port from WB.
REQ-008 PCSrc1  output  2  00 sequential, 01 j/jal target, 10 jr/jalr register target.
REQ-009 PCSrc2  output  1  1 = IF holds PC.
REQ-010 Jump_addr  output  32  jump target for IF.
REQ-011 regOption  output  2  IF/ID control: 00 load, 01 flush, 10 hold.
REQ-012 id_ex_pc_plus_4, id_ex_rs_data, id_ex_rt_data, id_ex_imm  output  32 each  ID/EX register fields.
REQ-013 id_ex_rs, id_ex_rt, id_ex_wr_reg  output  5 each  source/destination register numbers.
REQ-014 id_ex_ctrl  output  12  [11]reg_write [10]mem_read [9]mem_write [8:7]mem_to_reg(00 ALU,01 mem,10 PC+4) [6]alu_src [5:2]alu_op [1:0]branch(00 none,01 beq,10 bne).

Function
REQ-015 Decode MIPS subset: R add/addu/sub/subu/and/or/xor/nor/slt/sltu/sll/srl/sra/jr/jalr; I addi/addiu/andi/ori/xori/lui/slti/sltiu/lw/sw/beq/bne; J j/jal; other opcodes decode as nop (ctrl=0).
REQ-016 alu_op: 0 add,1 sub,2 and,3 or,4 xor,5 nor,6 slt,7 sltu,8 sll,9 srl,10 sra,11 lui; branches use sub.
REQ-017 id_ex_imm: sign-extended imm16 for arith/slt/lw/sw/beq/bne; zero-extended for andi/ori/xori; {imm16,16'b0} for lui; {27'b0,shamt} for shifts.
REQ-018 id_ex_wr_reg: rd for R-type, rt for I-type, RA_IDX for jal and for jalr with rd=0; writes to register 0 never take effect.
REQ-019 Register file: 32x32, combinational read, write on clk edge when wb_reg_write and wb_wr_reg!=0; register 0 reads 0.
REQ-020 Load-use hazard: id_ex_ctrl[10]=1, id_ex_wr_reg!=0 and equals rs (if used) or rt (if used by R-type, sw, beq, bne) -> PCSrc2=1, regOption=10, ID/EX loads bubble (all fields 0), PCSrc1=00.
REQ-021 j/jal: PCSrc1=01, Jump_addr={if_id_pc_plus_4[31:28],target26,2'b00}, regOption=01; jr/jalr: PCSrc1=10, Jump_addr=rs read value; instruction itself proceeds to ID/EX.
REQ-022 activeBranch=1: ID/EX loads bubble, regOption=01, PCSrc1=00, PCSrc2=0; overrides stall and jump.
REQ-023 Priority: activeBranch > load-use stall > jump > normal (regOption=00, PCSrc2=0, ID/EX loads decode).
REQ-024 jr/jalr whose rs matches a load in EX stalls first, redirects only after stall clears.
REQ-025 Hazard, jump and PC-control outputs combinational from current IF/ID and ID/EX state; ID/EX latency one cycle.

Reset
REQ-026 reset=1 at clk edge: all ID/EX outputs and all 32 registers 0; combinational outputs then PCSrc1=00, PCSrc2=0, regOption=00; mid-stall reset clears stall next cycle.

Configuration
REQ-027 ID_WB_BYPASS_EN defined: read of register equal to wb_wr_reg with wb_reg_write=1 (nonzero) returns wb_wr_data same cycle, including jr target; undefined: returns stored old value.

Verification
REQ-028 $1=5,$2=7 preloaded; add $3,$1,$2 -> next cycle id_ex_rs_data=5, rt_data=7, wr_reg=3, ctrl alu_op=0, reg_write=1.
REQ-029 lw $4,0($1) then add $5,$4,$2 -> one cycle PCSrc2=1, regOption=10, ID/EX bubble; add issues next cycle.
REQ-030 jal 0x0000100 at pc_plus_4=0x00400008 -> PCSrc1=01, Jump_addr=0x00000400, regOption=01, then id_ex_wr_reg=31, mem_to_reg=10.
REQ-031 activeBranch=1 with lw-use hazard present -> regOption=01, PCSrc2=0, ID/EX bubble.
REQ-032 WB writes $6=0xDEADBEEF while ID reads $6: 0xDEADBEEF with ID_WB_BYPASS_EN, old value without; write to $0 leaves $0 reading 0.
